// File: rtl/membus_arbiter_pkg.sv
// Bus request/response types and grant-FSM state encoding shared by the
// membus arbiter and its winner-select sub-module.
package membus_arbiter_pkg;

    localparam int BUS_AW = 64;
    localparam int BUS_DW = 64;
    localparam int BUS_SW = BUS_DW / 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic              valid;
        logic [BUS_AW-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic              valid;
        logic [BUS_AW-1:0] addr;
        msize_t            size;
        logic [BUS_SW-1:0] strobe;
        logic [BUS_DW-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [BUS_DW-1:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/membus_arb_pick.sv
// Combinational winner select between fetch and data requests.
// MEMBUS_ARB_RR_EN: round-robin on collision; otherwise dbus always wins.
module membus_arb_pick (
    input  logic ivalid,
    input  logic dvalid,
`ifdef MEMBUS_ARB_RR_EN
    input  logic last_d,
`endif
    output logic grant_i,
    output logic grant_d
);

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (ivalid && dvalid) begin
`ifdef MEMBUS_ARB_RR_EN
            grant_i = last_d;
            grant_d = !last_d;
`else
            grant_d = 1'b1;
`endif
        end else begin
            grant_i = ivalid;
            grant_d = dvalid;
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// Shares one single-beat memory port between ibus and dbus via a grant FSM.
// MEMBUS_ARB_RR_EN selects round-robin collision handling (default: dbus priority).
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter int AW = BUS_AW,
    parameter int DW = BUS_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  ibus_req_t       ireq,
    output ibus_resp_t      iresp,
    input  dbus_req_t       dreq,
    output dbus_resp_t      dresp,
    output logic            m_valid,
    output logic            m_write,
    output logic [AW-1:0]   m_addr,
    output logic [2:0]      m_size,
    output logic [DW/8-1:0] m_strobe,
    output logic [DW-1:0]   m_data,
    input  logic            m_ready,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy
);

    arb_state_t state;
    logic       grant_i, grant_d;
    logic       iack, dack;
`ifdef MEMBUS_ARB_RR_EN
    logic       last_d;
`endif

    membus_arb_pick u_pick (
        .ivalid  (ireq.valid),
        .dvalid  (dreq.valid),
`ifdef MEMBUS_ARB_RR_EN
        .last_d  (last_d),
`endif
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            m_valid  <= 1'b0;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_size   <= '0;
            m_strobe <= '0;
            m_data   <= '0;
`ifdef MEMBUS_ARB_RR_EN
            last_d   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= DGRANT;
                        m_valid  <= 1'b1;
                        m_write  <= |dreq.strobe;
                        m_addr   <= dreq.addr;
                        m_size   <= dreq.size;
                        m_strobe <= dreq.strobe;
                        m_data   <= dreq.data;
`ifdef MEMBUS_ARB_RR_EN
                        last_d   <= 1'b1;
`endif
                    end else if (grant_i) begin
                        state    <= IGRANT;
                        m_valid  <= 1'b1;
                        m_write  <= 1'b0;
                        m_addr   <= ireq.addr;
                        m_size   <= MSIZE4;
                        m_strobe <= '0;
                        m_data   <= '0;
`ifdef MEMBUS_ARB_RR_EN
                        last_d   <= 1'b0;
`endif
                    end
                end
                default: begin
                    // Requesters hold their fields until data_ok, so only the ack matters here.
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign iack = (state == IGRANT) && m_ready;
    assign dack = (state == DGRANT) && m_ready;

    always_comb begin
        iresp = '0;
        dresp = '0;
        if (iack) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
        end
        if (dack) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = m_rdata;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed self-checking bench for membus_arbiter (either arbitration build).
module tb_membus_arbiter;
    import membus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        m_valid, m_write, m_ready, busy;
    logic [63:0] m_addr, m_data, m_rdata;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;

    int checks = 0;
    int errors = 0;

    membus_arbiter dut (
        .clk(clk), .rst(rst), .ireq(ireq), .iresp(iresp), .dreq(dreq), .dresp(dresp),
        .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_data(m_data), .m_ready(m_ready), .m_rdata(m_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ireq = '0; dreq = '0; m_ready = 1'b0; m_rdata = '0;
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({m_write, m_addr, m_size, m_strobe, m_data} !== '0)
            begin errors++; $display("FAIL reset_m_fields got %h want 0", {m_write, m_addr, m_size, m_strobe, m_data}); end
        checks++; if ({iresp, dresp} !== '0) begin errors++; $display("FAIL reset_resp got %h want 0", {iresp, dresp}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lone_fetch();
        ireq.valid = 1'b1; ireq.addr = 64'h8000_0004;
        step();
        checks++; if (m_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL fetch_grant got v=%b b=%b want 1 1", m_valid, busy); end
        checks++; if (m_addr !== 64'h8000_0004) begin errors++; $display("FAIL fetch_addr got %h want 80000004", m_addr); end
        checks++; if (m_size !== 3'd2 || m_write !== 1'b0 || m_strobe !== 8'h00)
            begin errors++; $display("FAIL fetch_attr got size=%0d w=%b s=%h want 2 0 00", m_size, m_write, m_strobe); end
        step(); step();
        checks++; if (iresp.data_ok !== 1'b0) begin errors++; $display("FAIL fetch_early_ok got %b want 0", iresp.data_ok); end
        m_ready = 1'b1; m_rdata = 64'h1111_2222_3333_4444;
        #1;
        checks++; if (iresp.data_ok !== 1'b1 || iresp.addr_ok !== 1'b1 || iresp.data !== 32'h1111_2222)
            begin errors++; $display("FAIL fetch_resp got ok=%b data=%h want 1 11112222", iresp.data_ok, iresp.data); end
        checks++; if (dresp !== '0) begin errors++; $display("FAIL fetch_dresp_idle got %h want 0", dresp); end
        step();
        m_ready = 1'b0; ireq.valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL fetch_done got b=%b v=%b want 0 0", busy, m_valid); end
        step();
    endtask

    task automatic test_lone_store();
        dreq.valid = 1'b1; dreq.addr = 64'h100; dreq.size = MSIZE8;
        dreq.strobe = 8'hFF; dreq.data = 64'hDEAD_BEEF;
        step();
        checks++; if (m_write !== 1'b1 || m_strobe !== 8'hFF || m_data !== 64'hDEAD_BEEF)
            begin errors++; $display("FAIL store_fields got w=%b s=%h d=%h want 1 ff deadbeef", m_write, m_strobe, m_data); end
        checks++; if (m_addr !== 64'h100 || m_size !== 3'd3) begin errors++; $display("FAIL store_addr got %h/%0d want 100/3", m_addr, m_size); end
        m_ready = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF;
        #1;
        checks++; if (dresp.data_ok !== 1'b1 || dresp.data !== 64'h0123_4567_89AB_CDEF)
            begin errors++; $display("FAIL store_resp got ok=%b data=%h want 1 0123456789abcdef", dresp.data_ok, dresp.data); end
        checks++; if (iresp !== '0) begin errors++; $display("FAIL store_iresp_idle got %h want 0", iresp); end
        step();
        m_ready = 1'b0; dreq.valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL store_busy_drop got %b want 0", busy); end
        step();
    endtask

    // Last grant entering here is dbus. Both stay valid for two transactions,
    // then dbus drops; ibus must win the third in either build.
    task automatic test_collision();
        logic exp_d [3];
`ifdef MEMBUS_ARB_RR_EN
        exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b0;
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b0;
`endif
        ireq.valid = 1'b1; ireq.addr = 64'h2000;
        dreq.valid = 1'b1; dreq.addr = 64'h3000; dreq.size = MSIZE8;
        dreq.strobe = 8'h00; dreq.data = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (m_valid !== 1'b1 || m_addr !== (exp_d[k] ? 64'h3000 : 64'h2000))
                begin errors++; $display("FAIL coll_grant%0d got v=%b addr=%h want d=%b", k, m_valid, m_addr, exp_d[k]); end
            m_ready = 1'b1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
            #1;
            if (exp_d[k]) begin
                checks++; if (dresp.data_ok !== 1'b1 || iresp.data_ok !== 1'b0 || dresp.data !== 64'hAAAA_BBBB_CCCC_DDDD)
                    begin errors++; $display("FAIL coll_dresp%0d got d=%b i=%b data=%h", k, dresp.data_ok, iresp.data_ok, dresp.data); end
            end else begin
                checks++; if (iresp.data_ok !== 1'b1 || dresp.data_ok !== 1'b0 || iresp.data !== 32'hCCCC_DDDD)
                    begin errors++; $display("FAIL coll_iresp%0d got i=%b d=%b data=%h want lower word", k, iresp.data_ok, dresp.data_ok, iresp.data); end
            end
            step();
            m_ready = 1'b0;
            if (k == 1) dreq.valid = 1'b0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coll_idle%0d got %b want 0", k, busy); end
        end
        ireq.valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_and_stray();
        dreq.valid = 1'b1; dreq.addr = 64'h40; dreq.size = MSIZE8;
        dreq.strobe = 8'h0F; dreq.data = 64'h55;
        step();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmid_grant got %b want 1", m_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || m_addr !== '0)
            begin errors++; $display("FAIL rmid_async got v=%b b=%b a=%h want 0 0 0", m_valid, busy, m_addr); end
        dreq.valid = 1'b0;
        step();
        rst = 1'b0;
        m_ready = 1'b1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++; if (iresp !== '0 || dresp !== '0) begin errors++; $display("FAIL stray_resp got %h want 0", {iresp, dresp}); end
        step();
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL stray_state got b=%b v=%b want 0 0", busy, m_valid); end
        checks++; if (dresp.data_ok !== 1'b0 || iresp.data_ok !== 1'b0)
            begin errors++; $display("FAIL stray_ok got i=%b d=%b want 0 0", iresp.data_ok, dresp.data_ok); end
        m_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_lone_store();
        test_collision();
        test_reset_mid_and_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
